// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: latches the LFSR output as target on start and judges guesses.
// Optional idle-guess timeout is compiled in when GUESS_TIMEOUT_EN is defined.
module guess_game_ctrl #(
    parameter int WIDTH          = 8,
    parameter int MAX_TRIES      = 7,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    input  logic [WIDTH-1:0] range_min,
    input  logic [WIDTH-1:0] range_max,
    input  logic [WIDTH-1:0] rng_num,
    output logic             rng_en,
    output logic [WIDTH-1:0] target,
    output logic [1:0]       hint,
    output logic             hint_valid,
    output logic [3:0]       tries_left,
    output logic             busy,
    output logic             win,
    output logic             lose,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_LOW  = 2'b01;
    localparam logic [1:0] HINT_HIGH = 2'b10;
    localparam logic [1:0] HINT_HIT  = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [1:0]       hint_q, hint_d;
    logic             hint_valid_q, hint_valid_d;
    logic [3:0]       tries_q, tries_d;

    logic [WIDTH-1:0] eff_min, eff_max;
    logic             in_range;
    logic             tmo_expire;
    logic             wrong;

    // Inverted bounds fall back to the full range, mirroring the generator's protection.
    always_comb begin
        if (range_max >= range_min) begin
            eff_min = range_min;
            eff_max = range_max;
        end else begin
            eff_min = '0;
            eff_max = '1;
        end
    end

    assign in_range = (guess >= eff_min) && (guess <= eff_max);

`ifdef GUESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // A real guess or a restart in the expiry cycle wins over the timeout.
    assign tmo_expire = (state_q == S_PLAY) && !start && !guess_valid && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        timeout_d = tmo_expire;
        if ((state_q != S_PLAY) || start || guess_valid || tmo_expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_expire         = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        hint_d       = hint_q;
        hint_valid_d = 1'b0;
        tries_d      = tries_q;
        wrong        = 1'b0;

        if (start) begin
            state_d  = S_PLAY;
            target_d = rng_num;
            tries_d  = 4'(MAX_TRIES);
            hint_d   = HINT_NONE;
        end else if (state_q == S_PLAY) begin
            if (guess_valid) begin
                hint_valid_d = 1'b1;
                if (!in_range) begin
                    hint_d = HINT_NONE;
                end else if (guess == target_q) begin
                    hint_d  = HINT_HIT;
                    state_d = S_WIN;
                end else begin
                    hint_d = (guess < target_q) ? HINT_LOW : HINT_HIGH;
                    wrong  = 1'b1;
                end
            end else if (tmo_expire) begin
                hint_valid_d = 1'b1;
                hint_d       = HINT_NONE;
                wrong        = 1'b1;
            end

            // tries_left is at least 1 throughout PLAY, so the last miss lands exactly on 0.
            if (wrong) begin
                if (tries_q <= 4'd1) begin
                    tries_d = 4'd0;
                    state_d = S_LOSE;
                end else begin
                    tries_d = tries_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            hint_q       <= HINT_NONE;
            hint_valid_q <= 1'b0;
            tries_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            hint_q       <= hint_d;
            hint_valid_q <= hint_valid_d;
            tries_q      <= tries_d;
        end
    end

    assign rng_en     = (state_q != S_PLAY);
    assign target     = target_q;
    assign hint       = hint_q;
    assign hint_valid = hint_valid_q;
    assign tries_left = tries_q;
    assign busy       = (state_q == S_PLAY);
    assign win        = (state_q == S_WIN);
    assign lose       = (state_q == S_LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomized bench for guess_game_ctrl against a rule-level game model, plus directed literal checks.
module tb_guess_game_ctrl;

    localparam int MAXT = 7;
    localparam int TO   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [7:0] guess = 8'd0;
    logic [7:0] range_min = 8'd0;
    logic [7:0] range_max = 8'd255;
    logic [7:0] rng_num = 8'd0;
    logic       rng_en;
    logic [7:0] target;
    logic [1:0] hint;
    logic       hint_valid;
    logic [3:0] tries_left;
    logic       busy, win, lose, timeout;

    guess_game_ctrl #(.WIDTH(8), .MAX_TRIES(MAXT), .TIMEOUT_CYCLES(TO)) dut (
        .clk, .rst_n, .start, .guess_valid, .guess,
        .range_min, .range_max, .rng_num, .rng_en,
        .target, .hint, .hint_valid, .tries_left,
        .busy, .win, .lose, .timeout
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: mode 0 idle, 1 playing, 2 won, 3 lost.
    int         m_mode = 0;
    logic [7:0] m_target = 8'd0;
    int         m_tries = 0;
    int         m_idle = 0;
    logic [1:0] e_hint = 2'd0;
    logic       e_hv = 1'b0;
    logic       e_to = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_target = 8'd0; m_tries = 0; m_idle = 0;
        e_hint = 2'd0; e_hv = 1'b0; e_to = 1'b0;
    endtask

    function automatic logic [7:0] eff_lo();
        return (range_max >= range_min) ? range_min : 8'd0;
    endfunction

    function automatic logic [7:0] eff_hi();
        return (range_max >= range_min) ? range_max : 8'd255;
    endfunction

    task automatic model_step();
        bit miss;
        miss = 0;
        e_hv = 1'b0;
        e_to = 1'b0;
        if (start) begin
            m_mode = 1; m_target = rng_num; m_tries = MAXT; e_hint = 2'd0; m_idle = 0;
        end else if (m_mode == 1) begin
            if (guess_valid) begin
                m_idle = 0;
                e_hv = 1'b1;
                if (guess < eff_lo() || guess > eff_hi()) e_hint = 2'd0;
                else if (guess == m_target) begin e_hint = 2'd3; m_mode = 2; end
                else begin e_hint = (guess < m_target) ? 2'd1 : 2'd2; miss = 1; end
            end
`ifdef GUESS_TIMEOUT_EN
            else if (m_idle == TO - 1) begin
                m_idle = 0; e_hv = 1'b1; e_to = 1'b1; e_hint = 2'd0; miss = 1;
            end else begin
                m_idle++;
            end
`endif
            if (miss) begin
                m_tries--;
                if (m_tries == 0) m_mode = 3;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("target", target, m_target);
            chk("hint", hint, e_hint);
            chk("hint_valid", hint_valid, e_hv);
            chk("tries_left", tries_left, m_tries);
            chk("busy", busy, m_mode == 1);
            chk("win", win, m_mode == 2);
            chk("lose", lose, m_mode == 3);
            chk("timeout", timeout, e_to);
            chk("rng_en", rng_en, m_mode != 1);
        end
    end

    // Called at a falling edge; applies inputs for one rising edge and returns at the next falling edge.
    task automatic cyc(input bit s, input bit gv, input logic [7:0] g, input logic [7:0] rn);
        start = s; guess_valid = gv; guess = g; rng_num = rn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        start = 1'b0; guess_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_target"}, target, 0);
        chk({tag, "_hint"}, hint, 0);
        chk({tag, "_hv"}, hint_valid, 0);
        chk({tag, "_tries"}, tries_left, 0);
        chk({tag, "_status"}, {busy, win, lose, timeout}, 0);
        chk({tag, "_rng_en"}, rng_en, 1);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_vals(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int r;
    int sel;
    logic [7:0] g;

    initial begin
        #1 check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start with 0x5A over the full range.
        cyc(1, 0, 8'h00, 8'h5A);
        chk("start_target", target, 8'h5A);
        chk("start_tries", tries_left, 7);
        chk("start_busy", busy, 1);
        chk("start_rng_en", rng_en, 0);
        cyc(0, 1, 8'h10, 8'h11);
        chk("low_hint", hint, 2'b01);
        chk("low_hv", hint_valid, 1);
        chk("low_tries", tries_left, 6);
        cyc(0, 1, 8'hC0, 8'h12);
        chk("high_hint", hint, 2'b10);
        chk("high_tries", tries_left, 5);
        cyc(0, 1, 8'h5A, 8'h13);
        chk("hit_hint", hint, 2'b11);
        chk("hit_win", win, 1);
        chk("hit_rng_en", rng_en, 1);
        chk("hit_tries", tries_left, 5);

        // Seven misses lose the game; later guesses are ignored.
        cyc(1, 0, 8'h00, 8'h80);
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 8'h01, 8'h00);
            chk("miss_tries", tries_left, 7 - i);
        end
        chk("miss_lose", lose, 1);
        cyc(0, 1, 8'h80, 8'h00);
        chk("lost_hv", hint_valid, 0);

        // Bounded range and inverted bounds.
        cyc(1, 0, 8'h00, 8'h30);
        range_min = 8'd20; range_max = 8'd50;
        cyc(0, 1, 8'd60, 8'h00);
        chk("oor_hint", hint, 2'b00);
        chk("oor_hv", hint_valid, 1);
        chk("oor_tries", tries_left, 7);
        range_min = 8'd50; range_max = 8'd20;
        cyc(0, 1, 8'd60, 8'h00);
        chk("swap_hint", hint, 2'b10);
        chk("swap_tries", tries_left, 6);
        range_min = 8'd0; range_max = 8'd255;

        // start beats a simultaneous guess, then asynchronous reset mid-game.
        cyc(1, 1, 8'h01, 8'h33);
        chk("restart_target", target, 8'h33);
        chk("restart_tries", tries_left, 7);
        chk("restart_hv", hint_valid, 0);
        chk("restart_hint", hint, 2'b00);
        do_reset("midgame");

        // Idle guessing.
        cyc(1, 0, 8'h00, 8'h44);
        for (int i = 0; i < 9; i++) cyc(0, 0, 8'h00, 8'h00);
        chk("idle9_timeout", timeout, 0);
        cyc(0, 1, 8'h00, 8'h00);
        for (int i = 0; i < 9; i++) cyc(0, 0, 8'h00, 8'h00);
        chk("idle_after_guess_timeout", timeout, 0);
        cyc(0, 0, 8'h00, 8'h00);
`ifdef GUESS_TIMEOUT_EN
        chk("expire_timeout", timeout, 1);
        chk("expire_tries", tries_left, 5);
`else
        chk("no_timeout", timeout, 0);
        chk("no_timeout_tries", tries_left, 6);
`endif

        // Random play.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 4) begin
                range_min = 8'($urandom);
                range_max = 8'($urandom);
            end else if (r < 8) begin
                range_min = 8'd0;
                range_max = 8'd255;
            end
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1:    g = m_target;
                2:       g = eff_lo();
                3:       g = eff_hi();
                4:       g = m_target + 8'd1;
                default: g = 8'($urandom);
            endcase
            if (r == 199) do_reset("rand");
            else cyc(r < 6, $urandom_range(0, 2) == 0, g, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
